// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared types for the full adder cell.
//   carry_src_e : where the adder's effective carry-in comes from
//   carry_src() : decodes ser_en/ser_start into a carry source
// -----------------------------------------------------------------------------
package full_adder_pkg;

    typedef enum logic {
        CARRY_EXT = 1'b0,  // external Cin pin
        CARRY_SER = 1'b1   // internal serial carry register (Co_r)
    } carry_src_e;

    // A start bit always seeds from Cin, even in serial mode, so any carry
    // left over from a previous word is discarded.
    function automatic carry_src_e carry_src(input logic ser_en, input logic ser_start);
        return (ser_en && !ser_start) ? CARRY_SER : CARRY_EXT;
    endfunction

endpackage

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// One-bit half adder, purely combinational.
//   a, b : operand bits
//   s    : sum   = a ^ b
//   c    : carry = a & b
// -----------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder with registered result taps and an LSB-first bit-serial
// carry mode.
//   clk, rst_n     : clock, asynchronous active-low reset
//   A, B           : addend bits
//   Cin            : external carry-in
//   ser_en         : 1 = use the internal carry register instead of Cin
//   ser_start      : first bit of a serial word; seeds the carry from Cin
//   Sum, Co        : combinational sum / carry-out
//   Sum_r, Co_r    : registered Sum / Co (Co_r doubles as the serial carry)
// Parameter REG_OUT: 1 builds Sum_r/Co_r, 0 ties them to 0.
// -----------------------------------------------------------------------------
module full_adder
    import full_adder_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic Cin,
    input  logic ser_en,
    input  logic ser_start,
    output logic Sum,
    output logic Co,
    output logic Sum_r,
    output logic Co_r
);

    carry_src_e src;
    logic       c_eff;
    logic       s0;
    logic       c0;
    logic       c1;

    assign src   = carry_src(ser_en, ser_start);
    assign c_eff = (src == CARRY_SER) ? Co_r : Cin;

    half_adder u_ha0 (
        .a (A),
        .b (B),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (c_eff),
        .s (Sum),
        .c (c1)
    );

    // The two half-adder carries can never both be 1, so OR is exact.
    assign Co = c0 | c1;

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    Sum_r <= 1'b0;
                    Co_r  <= 1'b0;
                end else begin
                    Sum_r <= Sum;
                    Co_r  <= Co;
                end
            end
        end else begin : g_noreg
            // Without the register the serial carry reads as 0, so serial
            // mode degrades to adding each bit with carry-in 0.
            assign Sum_r = 1'b0;
            assign Co_r  = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Scoreboard bench for full_adder: expected values are queued when stimulus
// is driven and popped when the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;
    logic A, B, Cin, ser_en, ser_start;
    logic Sum, Co, Sum_r, Co_r;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [1:0] exp;
    } exp_t;

    exp_t sb[$];

    full_adder #(.REG_OUT(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .ser_en    (ser_en),
        .ser_start (ser_start),
        .Sum       (Sum),
        .Co        (Co),
        .Sum_r     (Sum_r),
        .Co_r      (Co_r)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [1:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [1:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", obs, ~obs);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    // Reference: arithmetic sum of three bits -> {carry, sum}
    function automatic logic [1:0] fa_model(input logic a, input logic b, input logic c);
        logic [1:0] t;
        t = 2'(a) + 2'(b) + 2'(c);
        return t;
    endfunction

    // LSB-first serial add of two 4-bit words; checks Sum each bit and the
    // final word carry in Co_r.
    task automatic serial_add(input string tag, input logic [3:0] aw, input logic [3:0] bw,
                              input logic cin0);
        logic       carry;
        logic [1:0] t;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ser_en    = 1'b1;
            ser_start = (i == 0);
            Cin       = cin0;
            A         = aw[i];
            B         = bw[i];
            t = fa_model(aw[i], bw[i], (i == 0) ? cin0 : carry);
            carry = t[1];
            sb_push($sformatf("%s_sum_bit%0d", tag, i), {1'b0, t[0]});
            #2;
            sb_check({1'b0, Sum});
        end
        sb_push($sformatf("%s_co_r", tag), {1'b0, carry});
        @(posedge clk);
        #1;
        sb_check({1'b0, Co_r});
    endtask

    initial begin
        logic [1:0] t;
        rst_n = 1'b0; A = 1'b0; B = 1'b0; Cin = 1'b0; ser_en = 1'b0; ser_start = 1'b0;

        // Reset state
        #1;
        sb_push("reset_regs", 2'b00);
        sb_check({Sum_r, Co_r});
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive combinational truth table, ser_en=0
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ser_en = 1'b0;
            A   = i[2];
            B   = i[1];
            Cin = i[0];
            t = fa_model(i[2], i[1], i[0]);
            sb_push($sformatf("comb_abc%0d%0d%0d", i[2], i[1], i[0]), {t[0], t[1]});
            #2;
            sb_check({Sum, Co});
        end

        // Registered path
        @(negedge clk);
        A = 1'b1; B = 1'b1; Cin = 1'b0;
        sb_push("reg_after_edge", 2'b01);
        @(posedge clk);
        #1;
        sb_check({Sum_r, Co_r});
        A = 1'b0; B = 1'b0; Cin = 1'b0;
        sb_push("reg_hold", 2'b01);
        #2;
        sb_check({Sum_r, Co_r});
        sb_push("reg_next_edge", 2'b00);
        @(posedge clk);
        #1;
        sb_check({Sum_r, Co_r});

        // Serial words
        serial_add("ser_7p1", 4'b0111, 4'b0001, 1'b0);
        serial_add("ser_fp1", 4'b1111, 4'b0001, 1'b0);

        // Re-seed while a carry is in flight: Co_r=1 here, start bit uses Cin
        @(negedge clk);
        ser_en = 1'b1; ser_start = 1'b1; A = 1'b0; B = 1'b0; Cin = 1'b1;
        sb_push("reseed_sum_co", 2'b10);
        #2;
        sb_check({Sum, Co});

        // Build Co_r=1 again, then reset asynchronously between edges
        A = 1'b1; B = 1'b1; Cin = 1'b0; ser_en = 1'b0; ser_start = 1'b0;
        @(posedge clk);
        #1;
        sb_push("pre_reset_co_r", 2'b01);
        sb_check({Sum_r, Co_r});
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        A = 1'b1; B = 1'b1; Cin = 1'b1; ser_en = 1'b0;
        #1;
        sb_push("async_reset_regs", 2'b00);
        sb_check({Sum_r, Co_r});
        sb_push("comb_during_reset", 2'b11);
        sb_check({Sum, Co});
        @(posedge clk);
        #1;
        sb_push("reset_wins_edge", 2'b00);
        sb_check({Sum_r, Co_r});

        // Release with carry cleared; a non-start serial bit sees carry 0
        @(negedge clk);
        A = 1'b0; B = 1'b0; Cin = 1'b1; ser_en = 1'b1; ser_start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        A = 1'b1; B = 1'b0;
        sb_push("post_reset_serial", 2'b10);
        #2;
        sb_check({Sum, Co});

        if (sb.size() != 0) check_eq("scoreboard_leftover", 2'(sb.size()), 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
